io_input_conditioner: RTL and testbench



---
 rtl/io_pkg.sv | 24 ++
 rtl/io_debounce_bit.sv | 54 +++++
 rtl/io_input_conditioner.sv | 82 ++++++++
 tb/tb_io_input_conditioner.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the board input conditioner and its port decode.
// Holds register addresses, in_port1 field offsets and the word packer.
package io_pkg;

    localparam logic [31:0] IO_IN_PORT0_ADDR = 32'hC0;
    localparam logic [31:0] IO_IN_PORT1_ADDR = 32'hC4;

    localparam int KEY_LSB = 0;
    localparam int CNT_LSB = 8;

    localparam int DB_CYCLES_DEFAULT = 50000;

    function automatic logic [31:0] pack_port1(
        input logic [7:0] cnt,
        input logic [3:0] key
    );
        logic [31:0] w;
        w = '0;
        w[CNT_LSB +: 8] = cnt;
        w[KEY_LSB +: 4] = key;
        return w;
    endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// One pin: two-flop synchroniser followed by a run-length debouncer.
// INVERT flips the synchronised level so active-low pins debounce as 1 = active.
module io_debounce_bit
    import io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = $clog2(DB_CYCLES),
    parameter bit RST_VAL   = 1'b0,
    parameter bit INVERT    = 1'b0
) (
    input  logic io_clk,
    input  logic resetn,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in;

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end

    assign w_in = r_s2 ^ INVERT;

    // Any sample matching the accepted level restarts the run.
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (w_in == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_stable <= w_in;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/io_input_conditioner.sv
// Board switch/button front end: debounced levels, press strobes, KEY0 count.
// Packs the results into the two words read back through the input port.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int SW_W      = 10,
    parameter int KEY_W     = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic             io_clk,
    input  logic             resetn,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [KEY_W-1:0] key_raw,
    output logic [31:0]      in_port0,
    output logic [31:0]      in_port1,
    output logic [KEY_W-1:0] key_pulse
);

    localparam int KN = (KEY_W < 4) ? KEY_W : 4;

    logic [SW_W-1:0]  w_sw_db;
    logic [KEY_W-1:0] w_key_db;
    logic [KEY_W-1:0] w_rise;
    logic [3:0]       w_key4;
    logic [KEY_W-1:0] r_key_db_d;
    logic [KEY_W-1:0] r_key_pulse;
    logic [7:0]       r_press_cnt;

    for (genvar g = 0; g < SW_W; g++) begin : g_sw
        io_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .RST_VAL   (1'b0),
            .INVERT    (1'b0)
        ) u_db (
            .io_clk (io_clk),
            .resetn (resetn),
            .raw    (sw_raw[g]),
            .stable (w_sw_db[g])
        );
    end

    // Keys idle high: sync flops reset released, level inverted to 1 = pressed.
    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        io_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .RST_VAL   (1'b1),
            .INVERT    (1'b1)
        ) u_db (
            .io_clk (io_clk),
            .resetn (resetn),
            .raw    (key_raw[g]),
            .stable (w_key_db[g])
        );
    end

    assign w_rise = w_key_db & ~r_key_db_d;

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_key_db_d  <= '0;
            r_key_pulse <= '0;
            r_press_cnt <= '0;
        end else begin
            r_key_db_d  <= w_key_db;
            r_key_pulse <= w_rise;
            r_press_cnt <= r_press_cnt + 8'(w_rise[0]);
        end
    end

    always_comb begin
        w_key4         = '0;
        w_key4[KN-1:0] = w_key_db[KN-1:0];
    end

    assign in_port0  = 32'(w_sw_db);
    assign in_port1  = pack_port1(r_press_cnt, w_key4);
    assign key_pulse = r_key_pulse;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with DB_CYCLES=4.
// Directed scenarios plus random pin activity against a window-based model.
module tb_io_input_conditioner;

    localparam int SW_W  = 10;
    localparam int KEY_W = 4;
    localparam int DB    = 4;
    localparam int NB    = SW_W + KEY_W;

    logic             io_clk = 1'b0;
    logic             resetn = 1'b0;
    logic [SW_W-1:0]  sw_raw = '0;
    logic [KEY_W-1:0] key_raw = '1;
    logic [31:0]      in_port0;
    logic [31:0]      in_port1;
    logic [KEY_W-1:0] key_pulse;

    int n_vec = 0;
    int n_err = 0;

    always #5 io_clk = ~io_clk;

    io_input_conditioner #(
        .SW_W      (SW_W),
        .KEY_W     (KEY_W),
        .DB_CYCLES (DB),
        .CNT_W     (2)
    ) dut (
        .io_clk    (io_clk),
        .resetn    (resetn),
        .sw_raw    (sw_raw),
        .key_raw   (key_raw),
        .in_port0  (in_port0),
        .in_port1  (in_port1),
        .key_pulse (key_pulse)
    );

    // Model: a level is accepted once the last DB synchronised samples
    // all disagree with it and all came after the previous acceptance.
    logic [NB-1:0]    hist[$];
    logic [NB-1:0]    seen_q[$];
    int               edge_n;
    int               last_flip[NB];
    logic [NB-1:0]    m_stable;
    logic [NB-1:0]    m_stable_d;
    logic [KEY_W-1:0] m_pulse;
    logic [7:0]       m_cnt;

    task automatic model_reset();
        hist.delete();
        seen_q.delete();
        edge_n = 0;
        foreach (last_flip[i]) last_flip[i] = -1000;
        m_stable   = '0;
        m_stable_d = '0;
        m_pulse    = '0;
        m_cnt      = '0;
    endtask

    task automatic model_edge();
        logic [NB-1:0] cur;
        logic [NB-1:0] seen;
        logic [NB-1:0] nxt;
        bit all_diff;
        cur  = {~key_raw, sw_raw};
        seen = (edge_n >= 2) ? hist[edge_n-2] : '0;
        hist.push_back(cur);
        seen_q.push_back(seen);
        m_pulse = m_stable[NB-1:SW_W] & ~m_stable_d[NB-1:SW_W];
        m_cnt   = m_cnt + 8'(m_pulse[0]);
        nxt = m_stable;
        for (int b = 0; b < NB; b++) begin
            if (edge_n >= DB - 1 && edge_n - last_flip[b] >= DB) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (seen_q[edge_n-j][b] == m_stable[b])
                        all_diff = 1'b0;
                if (all_diff) begin
                    nxt[b] = ~m_stable[b];
                    last_flip[b] = edge_n;
                end
            end
        end
        m_stable_d = m_stable;
        m_stable   = nxt;
        edge_n++;
    endtask

    task automatic step();
        @(posedge io_clk);
        if (!resetn) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp0;
        resetn  = 1'b0;
        sw_raw  = '0;
        key_raw = '1;
        model_reset();
        repeat (3) step();
        n_vec++;
        if (in_port0 !== 32'h0 || in_port1 !== 32'h0 || key_pulse !== 4'h0) begin
            n_err++;
            $display("FAIL reset_hold: p0=%h p1=%h pulse=%h want 0", in_port0, in_port1, key_pulse);
        end
        resetn = 1'b1;
        sw_raw = 10'h3FF;
        repeat (8) step();
        n_vec++;
        if (in_port0 !== 32'h3FF) begin
            n_err++;
            $display("FAIL reset_preload: p0=%h want 000003ff", in_port0);
        end
        #2 resetn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (in_port0 !== 32'h0 || in_port1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: p0=%h p1=%h want 0", in_port0, in_port1);
        end
        repeat (2) step();
        resetn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp0 = (k >= 6) ? 32'h3FF : 32'h0;
            n_vec++;
            if (in_port0 !== exp0 || in_port1 !== 32'h0) begin
                n_err++;
                $display("FAIL reset_release e%0d: p0=%h p1=%h want %h/0", k, in_port0, in_port1, exp0);
            end
        end
    endtask

    task automatic test_glitch();
        sw_raw = '0;
        repeat (8) step();
        n_vec++;
        if (in_port0 !== 32'h0) begin
            n_err++;
            $display("FAIL glitch_settle: p0=%h want 0", in_port0);
        end
        sw_raw = 10'h001;
        repeat (3) step();
        sw_raw = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_vec++;
            if (in_port0[0] !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_reject e%0d: bit0=%b want 0", k, in_port0[0]);
            end
        end
        sw_raw = 10'h001;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_vec++;
            if (in_port0[0] !== (k >= 6)) begin
                n_err++;
                $display("FAIL glitch_accept e%0d: bit0=%b want %b", k, in_port0[0], k >= 6);
            end
        end
        sw_raw = '0;
        repeat (8) step();
    endtask

    task automatic test_key_press();
        logic [7:0] exp_cnt;
        logic [3:0] exp_pulse;
        key_raw = 4'hE;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_cnt   = (k >= 7) ? 8'd1 : 8'd0;
            exp_pulse = (k == 7) ? 4'h1 : 4'h0;
            n_vec++;
            if (in_port1[0] !== (k >= 6) || key_pulse !== exp_pulse || in_port1[15:8] !== exp_cnt) begin
                n_err++;
                $display("FAIL key_press e%0d: key0=%b pulse=%h cnt=%0d want %b/%h/%0d",
                         k, in_port1[0], key_pulse, in_port1[15:8], k >= 6, exp_pulse, exp_cnt);
            end
        end
        key_raw = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (in_port1[0] !== (k < 6) || key_pulse !== 4'h0 || in_port1[15:8] !== 8'd1) begin
                n_err++;
                $display("FAIL key_release e%0d: key0=%b pulse=%h cnt=%0d want %b/0/1",
                         k, in_port1[0], key_pulse, in_port1[15:8], k < 6);
            end
        end
    endtask

    task automatic test_counter_wrap();
        int pulses;
        logic [7:0] exp_cnt;
        pulses = 0;
        #2 resetn = 1'b0;
        model_reset();
        #2 resetn = 1'b1;
        for (int p = 1; p <= 257; p++) begin
            key_raw = 4'hE;
            for (int k = 0; k < 6; k++) begin
                step();
                if (key_pulse[0]) pulses++;
            end
            key_raw = 4'hF;
            for (int k = 0; k < 6; k++) begin
                step();
                if (key_pulse[0]) pulses++;
            end
            exp_cnt = 8'(p);
            n_vec++;
            if (in_port1[15:8] !== exp_cnt) begin
                n_err++;
                $display("FAIL wrap_cnt p%0d: cnt=%0d want %0d", p, in_port1[15:8], exp_cnt);
            end
        end
        n_vec++;
        if (pulses != 257) begin
            n_err++;
            $display("FAIL wrap_pulses: got %0d want 257", pulses);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp0;
        logic [3:0]  expk;
        logic [3:0]  expp;
        logic [7:0]  expc;
        sw_raw  = 10'h3FF;
        key_raw = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp0 = (k >= 6) ? 32'h3FF : 32'h0;
            expk = (k >= 6) ? 4'hF : 4'h0;
            expp = (k == 7) ? 4'hF : 4'h0;
            expc = (k >= 7) ? 8'd2 : 8'd1;
            n_vec++;
            if (in_port0 !== exp0 || in_port1[3:0] !== expk ||
                key_pulse !== expp || in_port1[15:8] !== expc) begin
                n_err++;
                $display("FAIL simul e%0d: p0=%h key=%h pulse=%h cnt=%0d want %h/%h/%h/%0d",
                         k, in_port0, in_port1[3:0], key_pulse, in_port1[15:8], exp0, expk, expp, expc);
            end
        end
        sw_raw  = '0;
        key_raw = 4'hF;
        repeat (8) step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp0;
        sw_raw = 10'h020;
        repeat (4) step();
        n_vec++;
        if (in_port0 !== 32'h0) begin
            n_err++;
            $display("FAIL midrst_pre: p0=%h want 0", in_port0);
        end
        #2 resetn = 1'b0;
        model_reset();
        #2 resetn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp0 = (k >= 6) ? 32'h20 : 32'h0;
            n_vec++;
            if (in_port0 !== exp0) begin
                n_err++;
                $display("FAIL midrst e%0d: p0=%h want %h", k, in_port0, exp0);
            end
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] flip;
        logic [31:0]   e0;
        logic [31:0]   e1;
        for (int c = 0; c < 1500; c++) begin
            flip = '0;
            if ($urandom_range(3) != 0)
                for (int b = 0; b < NB; b++)
                    if ($urandom_range(5) == 0) flip[b] = 1'b1;
            sw_raw  = sw_raw ^ flip[SW_W-1:0];
            key_raw = key_raw ^ flip[NB-1:SW_W];
            step();
            e0 = {22'b0, m_stable[SW_W-1:0]};
            e1 = {16'b0, m_cnt, 4'b0, m_stable[NB-1:SW_W]};
            n_vec++;
            if (in_port0 !== e0 || in_port1 !== e1 || key_pulse !== m_pulse) begin
                n_err++;
                $display("FAIL random c%0d: p0=%h p1=%h pulse=%h want %h/%h/%h",
                         c, in_port0, in_port1, key_pulse, e0, e1, m_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_key_press();
        test_counter_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
